// File: rtl/jt51_mmr_pkg.sv
// Shared types for the register write queue: drain FSM states and queue entry layout.
package jt51_mmr_pkg;

   localparam int ENTRY_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } wrq_state_e;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wrq_entry_t;

endpackage

// File: rtl/jt51_wrq_fifo.sv
// Write-queue storage: circular buffer with read/write pointers, occupancy and registered full flag.
module jt51_wrq_fifo
   import jt51_mmr_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               push,
   input  logic               pop,
   input  logic [ENTRY_W-1:0] din,
   output logic [ENTRY_W-1:0] dout,
   output logic [AW:0]        level,
   output logic               empty,
   output logic               full
);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]        level_q, level_d;
   logic               full_q, full_d;
   logic               do_push, do_pop;

   assign do_pop  = pop && (level_q != '0);
   assign do_push = push && (!full_q || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
      // full is registered so busy changes on the same edge as level
      full_d = (level_d == (AW+1)'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush && !rst) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign level = level_q;
   assign empty = (level_q == '0);
   assign full  = full_q;

endmodule

// File: rtl/jt51_mmr_wrq.sv
// CPU-side write queue for the register file: address latch, drop logic and a guarded drain FSM.
// Optional drop counter output enabled by defining JT51_MMR_DROPCNT_EN.
module jt51_mmr_wrq
   import jt51_mmr_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int GUARD = 2,
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          write,
   input  logic          a0,
   input  logic [7:0]    d_in,
   input  logic          flush,
   input  logic          reg_busy,
   output logic          busy,
   output logic          up_stb,
   output logic [7:0]    up_addr,
   output logic [7:0]    up_data,
   output logic [LW-1:0] level
`ifdef JT51_MMR_DROPCNT_EN
   ,
   output logic [7:0]    drop_cnt
`endif
);

   localparam logic [3:0] GUARD_C = 4'(GUARD);

   wrq_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] sel_addr_q, sel_addr_d;
   logic       up_stb_q, up_stb_d;
   logic [7:0] up_addr_q, up_addr_d, up_data_q, up_data_d;
   wrq_entry_t head, new_entry;
   logic       empty, full, push, pop, drop;

   assign pop       = (state_q == ST_ISSUE) && !empty;
   assign push      = write && a0 && !flush && (!full || pop);
   assign drop      = write && a0 && !flush && full && !pop;
   assign new_entry = '{addr: sel_addr_q, data: d_in};

   jt51_wrq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (new_entry),
      .dout  (head),
      .level (level),
      .empty (empty),
      .full  (full)
   );

   always_comb begin
      sel_addr_d = sel_addr_q;
      if (write && !a0) sel_addr_d = d_in;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      up_stb_d  = 1'b0;
      up_addr_d = up_addr_q;
      up_data_d = up_data_q;
      case (state_q)
         ST_IDLE: begin
            // a flushing cycle must not launch an entry that is being discarded
            if (!empty && !reg_busy && !flush) begin
               state_d   = ST_ISSUE;
               up_stb_d  = 1'b1;
               up_addr_d = head.addr;
               up_data_d = head.data;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            cnt_d   = 4'd1;
         end
         ST_WAIT: begin
            if (cnt_q >= GUARD_C && !reg_busy) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q != 4'hF) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         sel_addr_q <= '0;
         up_stb_q   <= 1'b0;
         up_addr_q  <= '0;
         up_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_addr_q <= sel_addr_d;
         up_stb_q   <= up_stb_d;
         up_addr_q  <= up_addr_d;
         up_data_q  <= up_data_d;
      end
   end

`ifdef JT51_MMR_DROPCNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (flush)                            drop_cnt_d = '0;
      else if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) drop_cnt_q <= '0;
      else     drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`else
   logic unused_drop;
   assign unused_drop = drop;
`endif

   assign busy    = full;
   assign up_stb  = up_stb_q;
   assign up_addr = up_addr_q;
   assign up_data = up_data_q;

endmodule
